eaglesong_digest_driver: RTL and testbench

EAGLESONG_DIGEST_DRIVER -- requirements
Module: eaglesong_digest_driver

---
 rtl/eaglesong_digest_driver.sv | 169 ++++++++++++++++
 tb/tb_eaglesong_digest_driver.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eaglesong_digest_driver.sv
`default_nettype none
// ============================================================================
//  Module      : eaglesong_digest_driver
//  Description : Collects a byte-stream message (1..32 bytes), starts an
//                Eaglesong digest engine, waits for its result and presents
//                the digest on a valid/ready output with an error flag.
//                Optional feature macro: EAGLESONG_DRIVER_TIMEOUT_EN
//                (enables a WAIT-state timeout of TIMEOUT_CYCLES cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module eaglesong_digest_driver #(
   parameter int START_HOLD     = 2,
   parameter int TIMEOUT_CYCLES = 120
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   s_byte,
   input  logic         s_valid,
   input  logic         s_last,
   output logic         s_ready,
   output logic [255:0] eng_input_val,
   output logic [6:0]   eng_input_length_bytes,
   output logic         eng_start_eval,
   input  logic [255:0] eng_output_val,
   input  logic         eng_eval_output_ready,
   output logic [255:0] m_digest,
   output logic         m_valid,
   input  logic         m_ready,
   output logic         m_error,
   output logic         busy
);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } state_t;

   localparam logic [3:0] C_HOLD_LAST = 4'(START_HOLD - 1);

   // Reject out-of-range configurations at elaboration time.
   if (START_HOLD < 1 || START_HOLD > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
      $error("eaglesong_digest_driver: START_HOLD or TIMEOUT_CYCLES out of range");
   end

   state_t         state_q, state_d;
   logic [5:0]     count_q, count_d;     // bytes loaded so far, 0..32
   logic [255:0]   val_q,   val_d;
   logic [3:0]     hold_q,  hold_d;      // cycles spent in START
   logic [255:0]   digest_q, digest_d;
   logic           trunc_q, trunc_d;
   logic           tmo_q,   tmo_d;
`ifdef EAGLESONG_DRIVER_TIMEOUT_EN
   localparam logic [15:0] C_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0]    wcnt_q,  wcnt_d;      // cycles spent in WAIT
`endif

   // State register: reset forces LOAD at any time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= LOAD;
      else     state_q <= state_d;
   end

   // Datapath registers: message buffer, counters, digest and error flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= '0;
         val_q    <= '0;
         hold_q   <= '0;
         digest_q <= '0;
         trunc_q  <= 1'b0;
         tmo_q    <= 1'b0;
`ifdef EAGLESONG_DRIVER_TIMEOUT_EN
         wcnt_q   <= '0;
`endif
      end else begin
         count_q  <= count_d;
         val_q    <= val_d;
         hold_q   <= hold_d;
         digest_q <= digest_d;
         trunc_q  <= trunc_d;
         tmo_q    <= tmo_d;
`ifdef EAGLESONG_DRIVER_TIMEOUT_EN
         wcnt_q   <= wcnt_d;
`endif
      end
   end

   // Next-state, datapath updates and state-decoded outputs.
   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      val_d          = val_q;
      hold_d         = hold_q;
      digest_d       = digest_q;
      trunc_d        = trunc_q;
      tmo_d          = tmo_q;
`ifdef EAGLESONG_DRIVER_TIMEOUT_EN
      wcnt_d         = wcnt_q;
`endif
      s_ready        = 1'b0;
      eng_start_eval = 1'b0;
      m_valid        = 1'b0;
      busy           = 1'b1;

      case (state_q)
         LOAD: begin
            s_ready = 1'b1;
            busy    = 1'b0;
            if (s_valid) begin
               val_d[{count_q[4:0], 3'b000} +: 8] = s_byte;
               count_d = count_q + 6'd1;
               // A full buffer ends the message even without s_last.
               if (s_last || count_q == 6'd31) begin
                  state_d = START;
                  hold_d  = '0;
                  if (!s_last) trunc_d = 1'b1;
               end
            end
         end
         START: begin
            eng_start_eval = 1'b1;
            hold_d         = hold_q + 4'd1;
            if (hold_q == C_HOLD_LAST) begin
               state_d = WAIT;
`ifdef EAGLESONG_DRIVER_TIMEOUT_EN
               wcnt_d  = '0;
`endif
            end
         end
         WAIT: begin
            if (eng_eval_output_ready) begin
               digest_d = eng_output_val;
               state_d  = OUT;
            end
`ifdef EAGLESONG_DRIVER_TIMEOUT_EN
            else begin
               wcnt_d = wcnt_q + 16'd1;
               if (wcnt_q == C_TMO_LAST) begin
                  digest_d = '0;
                  tmo_d    = 1'b1;
                  state_d  = OUT;
               end
            end
`endif
         end
         OUT: begin
            m_valid = 1'b1;
            if (m_ready) begin
               // Clearing here keeps unused upper lanes zero for the next message.
               state_d = LOAD;
               count_d = '0;
               val_d   = '0;
               trunc_d = 1'b0;
               tmo_d   = 1'b0;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   assign eng_input_val          = val_q;
   assign eng_input_length_bytes = {1'b0, count_q};
   assign m_digest               = digest_q;
   assign m_error                = trunc_q | tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_eaglesong_digest_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eaglesong_digest_driver
//  Description : Directed self-checking bench for eaglesong_digest_driver.
//                Timeout scenario is compiled only with
//                EAGLESONG_DRIVER_TIMEOUT_EN defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eaglesong_digest_driver;

   localparam int START_HOLD     = 2;
   localparam int TIMEOUT_CYCLES = 120;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [7:0]   s_byte = '0;
   logic         s_valid = 1'b0;
   logic         s_last = 1'b0;
   logic         s_ready;
   logic [255:0] eng_input_val;
   logic [6:0]   eng_input_length_bytes;
   logic         eng_start_eval;
   logic [255:0] eng_output_val = '0;
   logic         eng_eval_output_ready = 1'b0;
   logic [255:0] m_digest;
   logic         m_valid;
   logic         m_ready = 1'b0;
   logic         m_error;
   logic         busy;

   int total = 0;
   int bad   = 0;

   localparam logic [255:0] C_HELLO_VAL = 256'h0A21646C726F77202C6F6C6C6548;
   localparam logic [255:0] C_HELLO_DIG =
      256'hD6727D073CE7EC1ECA9F52DBD0E4954B3F4DCB6B0B43C25D6162D141247E8664;

   eaglesong_digest_driver #(
      .START_HOLD     (START_HOLD),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .s_byte                 (s_byte),
      .s_valid                (s_valid),
      .s_last                 (s_last),
      .s_ready                (s_ready),
      .eng_input_val          (eng_input_val),
      .eng_input_length_bytes (eng_input_length_bytes),
      .eng_start_eval         (eng_start_eval),
      .eng_output_val         (eng_output_val),
      .eng_eval_output_ready  (eng_eval_output_ready),
      .m_digest               (m_digest),
      .m_valid                (m_valid),
      .m_ready                (m_ready),
      .m_error                (m_error),
      .busy                   (busy)
   );

   always #5 clk = ~clk;

   // Offer one byte for one clock; returns 1 ns after the edge.
   task automatic send_byte(input logic [7:0] b, input logic last);
      s_byte  = b;
      s_valid = 1'b1;
      s_last  = last;
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Engine model: after wait_cycles edges, present a digest for one cycle.
   task automatic engine_respond(input int wait_cycles, input logic [255:0] d);
      repeat (wait_cycles) @(posedge clk);
      #1;
      eng_output_val        = d;
      eng_eval_output_ready = 1'b1;
      @(posedge clk); #1;
      eng_eval_output_ready = 1'b0;
      eng_output_val        = '0;
   endtask

   // Complete the output handshake in one cycle.
   task automatic handshake();
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({s_ready, eng_start_eval, m_valid, m_error, busy} !== 5'b10000) begin
         bad++;
         $display("FAIL reset_ctrl: got %b want 10000", {s_ready, eng_start_eval, m_valid, m_error, busy});
      end
      total++;
      if (eng_input_val !== '0 || eng_input_length_bytes !== 7'd0 || m_digest !== '0) begin
         bad++;
         $display("FAIL reset_data: val=%h len=%0d dig=%h want zeros", eng_input_val, eng_input_length_bytes, m_digest);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_hello();
      logic [7:0] msg [14];
      msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
              8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};
      for (int i = 0; i < 14; i++) send_byte(msg[i], (i == 13));
      // Cycle N+1
      total++;
      if (eng_input_val !== C_HELLO_VAL || eng_input_length_bytes !== 7'd14) begin
         bad++;
         $display("FAIL hello_load: val=%h len=%0d want %h len=14", eng_input_val, eng_input_length_bytes, C_HELLO_VAL);
      end
      total++;
      if (eng_start_eval !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL hello_start1: start=%b s_ready=%b busy=%b want 1 0 1", eng_start_eval, s_ready, busy);
      end
      @(posedge clk); #1;
      total++;
      if (eng_start_eval !== 1'b1) begin
         bad++;
         $display("FAIL hello_start2: start=%b want 1", eng_start_eval);
      end
      @(posedge clk); #1;
      total++;
      if (eng_start_eval !== 1'b0 || m_valid !== 1'b0) begin
         bad++;
         $display("FAIL hello_start_end: start=%b m_valid=%b want 0 0", eng_start_eval, m_valid);
      end
      engine_respond(27, C_HELLO_DIG);
      total++;
      if (m_valid !== 1'b1 || m_digest !== C_HELLO_DIG || m_error !== 1'b0) begin
         bad++;
         $display("FAIL hello_result: valid=%b err=%b dig=%h want 1 0 %h", m_valid, m_error, m_digest, C_HELLO_DIG);
      end
      total++;
      if (eng_input_val !== C_HELLO_VAL || eng_input_length_bytes !== 7'd14) begin
         bad++;
         $display("FAIL hello_hold: val=%h len=%0d want unchanged", eng_input_val, eng_input_length_bytes);
      end
   endtask

   task automatic test_backpressure();
      int stable_bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (m_valid !== 1'b1 || m_digest !== C_HELLO_DIG || m_error !== 1'b0 || s_ready !== 1'b0)
            stable_bad++;
         @(posedge clk); #1;
      end
      total++;
      if (stable_bad !== 0) begin
         bad++;
         $display("FAIL backpressure_stable: unstable_cycles=%0d want 0", stable_bad);
      end
      handshake();
      total++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL handshake_to_load: valid=%b s_ready=%b busy=%b want 0 1 0", m_valid, s_ready, busy);
      end
      total++;
      if (eng_input_val !== '0 || eng_input_length_bytes !== 7'd0) begin
         bad++;
         $display("FAIL load_clear: val=%h len=%0d want 0 0", eng_input_val, eng_input_length_bytes);
      end
   endtask

   task automatic test_truncation();
      logic [255:0] exp_val;
      for (int i = 0; i < 32; i++) begin
         exp_val[i*8 +: 8] = 8'(i);
         send_byte(8'(i), 1'b0);
      end
      total++;
      if (s_ready !== 1'b0 || eng_start_eval !== 1'b1 || eng_input_length_bytes !== 7'd32) begin
         bad++;
         $display("FAIL trunc_end: s_ready=%b start=%b len=%0d want 0 1 32", s_ready, eng_start_eval, eng_input_length_bytes);
      end
      // An extra byte offered outside LOAD must be ignored.
      send_byte(8'hFF, 1'b1);
      total++;
      if (eng_input_val !== exp_val || eng_input_val[255:248] !== 8'h1F) begin
         bad++;
         $display("FAIL trunc_val: val=%h want %h", eng_input_val, exp_val);
      end
      engine_respond(3, 256'h1234);
      total++;
      if (m_valid !== 1'b1 || m_error !== 1'b1 || m_digest !== 256'h1234) begin
         bad++;
         $display("FAIL trunc_result: valid=%b err=%b dig=%h want 1 1 1234", m_valid, m_error, m_digest);
      end
      handshake();
      total++;
      if (m_error !== 1'b0 || s_ready !== 1'b1) begin
         bad++;
         $display("FAIL trunc_clear: err=%b s_ready=%b want 0 1", m_error, s_ready);
      end
   endtask

   task automatic test_reset_mid_wait();
      send_byte(8'h55, 1'b1);
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      total++;
      if ({s_ready, eng_start_eval, m_valid, m_error, busy} !== 5'b10000 ||
          eng_input_val !== '0 || eng_input_length_bytes !== 7'd0 || m_digest !== '0) begin
         bad++;
         $display("FAIL reset_async: ctrl=%b val=%h len=%0d dig=%h want 10000 zeros",
                  {s_ready, eng_start_eval, m_valid, m_error, busy}, eng_input_val, eng_input_length_bytes, m_digest);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      send_byte(8'hAB, 1'b1);
      total++;
      if (eng_input_val !== 256'hAB || eng_input_length_bytes !== 7'd1 || eng_start_eval !== 1'b1) begin
         bad++;
         $display("FAIL after_reset_msg: val=%h len=%0d start=%b want AB 1 1", eng_input_val, eng_input_length_bytes, eng_start_eval);
      end
      engine_respond(4, 256'hCAFE);
      total++;
      if (m_valid !== 1'b1 || m_error !== 1'b0 || m_digest !== 256'hCAFE) begin
         bad++;
         $display("FAIL after_reset_result: valid=%b err=%b dig=%h want 1 0 CAFE", m_valid, m_error, m_digest);
      end
      handshake();
   endtask

`ifdef EAGLESONG_DRIVER_TIMEOUT_EN
   task automatic test_timeout();
      int k = 0;
      send_byte(8'h01, 1'b1);
      while (m_valid !== 1'b1 && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      total++;
      if (k !== START_HOLD + TIMEOUT_CYCLES) begin
         bad++;
         $display("FAIL timeout_latency: cycles=%0d want %0d", k, START_HOLD + TIMEOUT_CYCLES);
      end
      total++;
      if (m_valid !== 1'b1 || m_digest !== '0 || m_error !== 1'b1) begin
         bad++;
         $display("FAIL timeout_result: valid=%b dig=%h err=%b want 1 0 1", m_valid, m_digest, m_error);
      end
      handshake();
   endtask
`endif

   initial begin
      test_reset();
      test_hello();
      test_backpressure();
      test_truncation();
      test_reset_mid_wait();
`ifdef EAGLESONG_DRIVER_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute guard against a stuck run.
   initial begin
      #200000;
      $display("FAIL watchdog: sim time exceeded, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
`default_nettype wire
